qspi_read_ctrl: RTL
===================

QSPI_READ_CTRL -- requirements
Module: qspi_read_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles, legal range 1..255.
REQ-002 Parameter DUMMY_CYCLES, default 8: SCK cycles between address and data in quad mode.
REQ-003 Port clk, input, 1: the single clock for all logic.
REQ-004 Port rst_b, input, 1: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1: read request offered.
REQ-006 Port req_ready, output, 1: request accepted in the cycle where req_valid and req_ready are both high.
REQ-007 Port req_addr, input, 24: flash byte address.
REQ-008 Port req_len, input, 8: byte count; 0 encodes 256.
REQ-009 Port req_quad, input, 1: 1 selects quad-output read (0x6B); 0 selects single read (0x03).
REQ-010 Port qspi_sck, output, 1: flash clock, SPI mode 0, idles low.
REQ-011 Port qspi_cs_n, output, 1: chip select, active low.
REQ-012 Port qspi_d_out and qspi_d_oe, outputs, 4 each: IO drive value and per-bit output enable.
REQ-013 Port qspi_d_in, input, 4: IO sample.
REQ-014 Port rd_valid, output, 1: rd_data is valid.
REQ-015 Port rd_ready, input, 1: sink accepts the byte.
REQ-016 Port rd_data, output, 8: received byte.
REQ-017 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 The FSM SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA and CSHI.
REQ-019 req_ready SHALL be high only in IDLE, with no rd_valid pending.
REQ-020 On accept, the block SHALL latch addr, len and quad, drive cs_n low and enter CMD; the first SCK rising edge SHALL occur no earlier than CLK_DIV clk cycles after cs_n falls.
REQ-021 SCK toggle rule: toggle every CLK_DIV clk cycles while active.
  - Outputs change only on SCK falling edges (or at cs_n fall for the first bit).
  - qspi_d_in is sampled in the clk cycle that raises SCK.
REQ-022 CMD SHALL shift the opcode MSB-first on d_out[0] over 8 SCK cycles, with d_oe=4'b0001.
REQ-023 ADDR SHALL shift the address MSB-first on d_out[0] over 24 SCK cycles.
REQ-024 After ADDR, quad mode SHALL enter DUMMY and single mode SHALL enter DATA.
REQ-025 DUMMY SHALL last exactly DUMMY_CYCLES SCK cycles with d_oe=4'b0000; DUMMY_CYCLES=0 SHALL skip the state.
REQ-026 DATA, single mode: d_oe=0; sample d_in[1], 8 SCK cycles per byte, MSB first.
REQ-027 DATA, quad mode: d_oe=0; sample d_in[3:0], 2 SCK cycles per byte, high nibble first.
REQ-028 Each completed byte SHALL load rd_data and set rd_valid in the next clk cycle; rd_valid SHALL hold with rd_data stable until rd_ready.
REQ-029 Backpressure: if a byte completes while rd_valid is still high, SCK SHALL be held low and the counters frozen until the handshake completes; no byte is ever dropped or overwritten.
REQ-030 After the final byte is sampled, the block SHALL enter CSHI: cs_n high, SCK low, d_oe=0, held for 2*CLK_DIV clk cycles, then IDLE.
REQ-031 A new request SHALL NOT be accepted until the last rd_valid has been consumed.
REQ-032 The byte counter SHALL be 9 bits wide so that len 0 yields exactly 256 bytes.
REQ-033 Simultaneous rd_ready and byte completion SHALL both take effect: the pending byte pops and the new byte loads, with no stall.

Reset
REQ-034 While rst_b=0, the block SHALL hold the following values:
  - State IDLE, req_ready=1, busy=0.
  - qspi_cs_n=1, qspi_sck=0, d_out=0, d_oe=0.
  - rd_valid=0, rd_data=0.
REQ-035 A reset asserted mid-transfer SHALL take effect immediately (asynchronously): cs_n high, partial byte discarded; the first request after reset restarts with CMD.

Verification
REQ-036 Single read, addr=0x000100, len=4, CLK_DIV=2, rd_ready=1 -> bus shows opcode 0x03 then 0x000100; the sink receives 4 bytes matching the flash model; exactly 64 SCK rising edges; cs_n high within 4 clk cycles of the last edge.
REQ-037 Quad read, addr=0xABCDEF, len=2, DUMMY_CYCLES=8 -> opcode 0x6B, 24 address bits, 8 SCK cycles with d_oe=0, then 4 data SCK cycles; bytes match the model.
REQ-038 Backpressure: len=3, rd_ready held low for 50 cycles after the first rd_valid -> SCK frozen low, rd_data stable; all 3 bytes delivered in order after rd_ready rises.
REQ-039 len=0 single read -> exactly 256 bytes delivered, then busy falls.
REQ-040 rst_b pulsed low during ADDR -> cs_n=1, rd_valid=0 in the same cycle; a following request for len=1 completes normally.
REQ-041 req_valid held high continuously with len=1 -> cs_n high for at least 2*CLK_DIV clk cycles between transfers; no request accepted while busy=1.

Source files
------------

// File: rtl/qspi_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_read_ctrl
//  Description : Serial-flash read controller. Issues single (0x03) or
//                quad-output (0x6B) reads with a 24-bit address and streams
//                the returned bytes out over a valid/ready interface, with
//                SCK held low whenever the byte sink applies backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_read_ctrl #(
    parameter int CLK_DIV      = 2,   // SCK half-period in clk cycles (1..255)
    parameter int DUMMY_CYCLES = 8    // dummy SCK cycles in quad mode
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        req_quad,
    output logic        qspi_sck,
    output logic        qspi_cs_n,
    output logic [3:0]  qspi_d_out,
    output logic [3:0]  qspi_d_oe,
    input  logic [3:0]  qspi_d_in,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        busy
);

    localparam logic [7:0] C_OP_SINGLE  = 8'h03;
    localparam logic [7:0] C_OP_QUAD    = 8'h6B;
    localparam logic [7:0] C_DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [8:0] C_CSHI_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] C_DUMMY_LAST = 9'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam bit         C_HAS_DUMMY  = (DUMMY_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_CSHI  = 3'd5
    } state_t;

    state_t      state_q,  state_d;
    logic [7:0]  div_q,    div_d;      // SCK half-period divider
    logic        sck_q,    sck_d;
    logic        cs_n_q,   cs_n_d;
    logic [31:0] shift_q,  shift_d;    // opcode + address, MSB goes out first
    logic [8:0]  cnt_q,    cnt_d;      // SCK cycles in phase, or CSHI hold count
    logic        quad_q,   quad_d;
    logic [8:0]  left_q,   left_d;     // bytes still to receive (256 fits)
    logic [6:0]  rx_q,     rx_d;       // partially assembled byte
    logic [2:0]  rx_cnt_q, rx_cnt_d;   // samples taken for current byte
    logic        last_q,   last_d;     // final byte already sampled
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q,  rd_data_d;

    logic       w_active;
    logic       w_tick;
    logic       w_rise;
    logic       w_fall;
    logic       w_byte_done;
    logic [7:0] w_new_byte;
    logic       w_stall;
    logic       w_req_ready;

    assign w_active    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                         (state_q == S_DUMMY) || (state_q == S_DATA);
    assign w_tick      = (div_q == C_DIV_LAST);
    assign w_rise      = w_tick && !sck_q;
    assign w_fall      = w_tick && sck_q;
    assign w_byte_done = quad_q ? (rx_cnt_q == 3'd1) : (rx_cnt_q == 3'd7);
    assign w_new_byte  = quad_q ? {rx_q[3:0], qspi_d_in} : {rx_q, qspi_d_in[1]};
    // A byte about to complete while the previous one is still unconsumed
    // keeps SCK low and freezes every counter until the sink takes it.
    assign w_stall     = (state_q == S_DATA) && w_rise && w_byte_done &&
                         rd_valid_q && !rd_ready;
    assign w_req_ready = (state_q == S_IDLE) && !rd_valid_q;

    // Next-state and datapath update for the whole read sequence.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        quad_d     = quad_q;
        left_d     = left_q;
        rx_d       = rx_q;
        rx_cnt_d   = rx_cnt_q;
        last_d     = last_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !rd_ready;

        if (w_active && !w_stall) begin
            div_d = w_tick ? 8'd0 : div_q + 8'd1;
            if (w_tick) begin
                sck_d = !sck_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && w_req_ready) begin
                    state_d  = S_CMD;
                    cs_n_d   = 1'b0;
                    sck_d    = 1'b0;
                    div_d    = 8'd0;
                    cnt_d    = 9'd0;
                    shift_d  = {(req_quad ? C_OP_QUAD : C_OP_SINGLE), req_addr};
                    quad_d   = req_quad;
                    left_d   = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    rx_d     = 7'd0;
                    rx_cnt_d = 3'd0;
                    last_d   = 1'b0;
                end
            end
            S_CMD: begin
                if (w_fall) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (cnt_q == 9'd7) begin
                        state_d = S_ADDR;
                        cnt_d   = 9'd0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_ADDR: begin
                if (w_fall) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (cnt_q == 9'd23) begin
                        cnt_d   = 9'd0;
                        state_d = (quad_q && C_HAS_DUMMY) ? S_DUMMY : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_DUMMY: begin
                if (w_fall) begin
                    if (cnt_q == C_DUMMY_LAST) begin
                        cnt_d   = 9'd0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_rise && !w_stall) begin
                    if (w_byte_done) begin
                        rd_data_d  = w_new_byte;
                        rd_valid_d = 1'b1;
                        rx_cnt_d   = 3'd0;
                        left_d     = left_q - 9'd1;
                        if (left_q == 9'd1) begin
                            last_d = 1'b1;
                        end
                    end else begin
                        rx_d     = w_new_byte[6:0];
                        rx_cnt_d = rx_cnt_q + 3'd1;
                    end
                end
                // Finish the SCK cycle of the last sample, then release CS.
                if (w_fall && last_q) begin
                    state_d = S_CSHI;
                    cs_n_d  = 1'b1;
                    cnt_d   = 9'd0;
                end
            end
            S_CSHI: begin
                if (cnt_q == C_CSHI_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset returns the bus to idle at once.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            div_q      <= 8'd0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            shift_q    <= 32'd0;
            cnt_q      <= 9'd0;
            quad_q     <= 1'b0;
            left_q     <= 9'd0;
            rx_q       <= 7'd0;
            rx_cnt_q   <= 3'd0;
            last_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            quad_q     <= quad_d;
            left_q     <= left_d;
            rx_q       <= rx_d;
            rx_cnt_q   <= rx_cnt_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign qspi_sck   = sck_q;
    assign qspi_cs_n  = cs_n_q;
    assign qspi_d_oe  = ((state_q == S_CMD) || (state_q == S_ADDR)) ? 4'b0001 : 4'b0000;
    assign qspi_d_out = ((state_q == S_CMD) || (state_q == S_ADDR)) ?
                        {3'b000, shift_q[31]} : 4'b0000;
    assign req_ready  = w_req_ready;
    assign busy       = (state_q != S_IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

endmodule
`default_nettype wire
